// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg : shared constants and state encoding for the FP add/sub back end
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fp_pkg;

  localparam int MANT_W  = 24;                    // mantissa incl. hidden bit
  localparam int EXP_W   = 8;                     // exponent field
  localparam int BIAS    = 127;
  localparam int EXP_INF = 255;
  localparam int WORD_W  = 1 + EXP_W + MANT_W - 1; // packed IEEE word
  localparam int EXPI_W  = EXP_W + 2;              // internal exponent, room for +2

  localparam logic [WORD_W-1:0] FP_POS_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fp_normalize_pack_if.sv
// ---------------------------------------------------------------------------
// fp_normalize_pack_if : adder-result / packed-result bus of the back end
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fp_normalize_pack_if;
  import fp_pkg::*;

  logic                en;
  logic                in_ready;
  logic [MANT_W-1:0]   sum;
  logic                c_out;
  logic                sign_in;
  logic [EXP_W-1:0]    exp_in;
  logic [WORD_W-1:0]   result;
  logic                done;
  logic                busy;
  logic                overflow;

  modport master (
    output en, in_ready, sum, c_out, sign_in, exp_in,
    input  result, done, busy, overflow
  );

  modport slave (
    input  en, in_ready, sum, c_out, sign_in, exp_in,
    output result, done, busy, overflow
  );

endinterface

`default_nettype wire

// File: rtl/fp_round_pack.sv
// ---------------------------------------------------------------------------
// fp_round_pack : round-to-nearest-even on guard bit and IEEE-754 packing
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp_round_pack
  import fp_pkg::*;
(
  input  logic [MANT_W:0]   i_mant,
  input  logic              i_guard,
  input  logic [EXPI_W-1:0] i_exp,
  input  logic              i_sgn,
  output logic [WORD_W-1:0] o_result,
  output logic              o_overflow
);

  logic              w_inc;
  logic [MANT_W:0]   w_mant_inc;
  logic [MANT_W:0]   w_mant_rnd;
  logic [EXPI_W-1:0] w_exp_rnd;

  // Guard alone marks an exact half: bump only when that makes the LSB even.
  assign w_inc      = i_guard & i_mant[0];
  assign w_mant_inc = i_mant + {{MANT_W{1'b0}}, w_inc};

  always_comb begin
    w_mant_rnd = w_mant_inc;
    w_exp_rnd  = i_exp;
    if (w_mant_inc[MANT_W]) begin
      w_mant_rnd = w_mant_inc >> 1;
      w_exp_rnd  = i_exp + EXPI_W'(1);
    end
  end

  always_comb begin
    o_result   = FP_POS_ZERO;
    o_overflow = 1'b0;
    if (w_mant_rnd == '0) begin
      o_result = FP_POS_ZERO;
    end else if (w_exp_rnd >= EXPI_W'(EXP_INF)) begin
      o_result   = {i_sgn, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
      o_overflow = 1'b1;
    end else if (!w_mant_rnd[MANT_W-1]) begin
      o_result = {i_sgn, {EXP_W{1'b0}}, w_mant_rnd[MANT_W-2:0]};
    end else begin
      o_result = {i_sgn, w_exp_rnd[EXP_W-1:0], w_mant_rnd[MANT_W-2:0]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_normalize_pack.sv
// ---------------------------------------------------------------------------
// fp_normalize_pack : sequential normalizer, rounder and IEEE-754 packer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp_normalize_pack
  import fp_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  fp_normalize_pack_if.slave  io_bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_rdy_q;
  logic [MANT_W:0]   r_mant;
  logic [MANT_W:0]   w_mant_nxt;
  logic [EXPI_W-1:0] r_exp;
  logic [EXPI_W-1:0] w_exp_nxt;
  logic              r_sgn;
  logic              w_sgn_nxt;
  logic              r_guard;
  logic              w_guard_nxt;
  logic [WORD_W-1:0] r_result;
  logic              r_done;
  logic              r_busy;
  logic              r_overflow;
  logic              w_capture;
  logic [EXPI_W-1:0] w_exp_in_clamped;
  logic [WORD_W-1:0] w_rp_result;
  logic              w_rp_overflow;

  // ROUND is the last cycle of an operation, so a fresh operand may be
  // captured on the same edge that registers the finished result.
  assign w_capture = io_bus.in_ready & ~r_rdy_q &
                     ((r_state == IDLE) | (r_state == ROUND));

  assign w_exp_in_clamped = (io_bus.exp_in == '0) ? EXPI_W'(1) : EXPI_W'(io_bus.exp_in);

  always_comb begin
    w_state_nxt = r_state;
    w_mant_nxt  = r_mant;
    w_exp_nxt   = r_exp;
    w_sgn_nxt   = r_sgn;
    w_guard_nxt = r_guard;
    case (r_state)
      IDLE: begin
        if (w_capture) begin
          w_state_nxt = NORM;
          w_mant_nxt  = {io_bus.c_out, io_bus.sum};
          w_exp_nxt   = w_exp_in_clamped;
          w_sgn_nxt   = io_bus.sign_in;
          w_guard_nxt = 1'b0;
        end
      end
      NORM: begin
        if (r_mant[MANT_W]) begin
          {w_mant_nxt, w_guard_nxt} = {1'b0, r_mant};
          w_exp_nxt   = r_exp + EXPI_W'(1);
          w_state_nxt = ROUND;
        end else if ((r_mant == '0) || r_mant[MANT_W-1] || (r_exp <= EXPI_W'(1))) begin
          w_state_nxt = ROUND;
        end else begin
          w_mant_nxt = r_mant << 1;
          w_exp_nxt  = r_exp - EXPI_W'(1);
        end
      end
      ROUND: begin
        w_state_nxt = IDLE;
        if (w_capture) begin
          w_state_nxt = NORM;
          w_mant_nxt  = {io_bus.c_out, io_bus.sum};
          w_exp_nxt   = w_exp_in_clamped;
          w_sgn_nxt   = io_bus.sign_in;
          w_guard_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else if (io_bus.en) begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdy_q    <= 1'b0;
      r_mant     <= '0;
      r_exp      <= '0;
      r_sgn      <= 1'b0;
      r_guard    <= 1'b0;
      r_result   <= FP_POS_ZERO;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (io_bus.en) begin
      r_rdy_q <= io_bus.in_ready;
      r_mant  <= w_mant_nxt;
      r_exp   <= w_exp_nxt;
      r_sgn   <= w_sgn_nxt;
      r_guard <= w_guard_nxt;
      r_done  <= (r_state == ROUND);
      if (r_state == ROUND) begin
        r_result   <= w_rp_result;
        r_overflow <= w_rp_overflow;
      end
      if (w_capture) begin
        r_busy <= 1'b1;
      end else if (r_state == ROUND) begin
        r_busy <= 1'b0;
      end
    end
  end

  fp_round_pack u_round_pack (
    .i_mant     (r_mant),
    .i_guard    (r_guard),
    .i_exp      (r_exp),
    .i_sgn      (r_sgn),
    .o_result   (w_rp_result),
    .o_overflow (w_rp_overflow)
  );

  assign io_bus.result   = r_result;
  assign io_bus.done     = r_done;
  assign io_bus.busy     = r_busy;
  assign io_bus.overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_fp_normalize_pack.sv
// ---------------------------------------------------------------------------
// tb_fp_normalize_pack : vector table, corner sequences and random ops
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fp_normalize_pack;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fp_normalize_pack_if bus ();

  fp_normalize_pack dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  typedef struct {
    logic        c;
    logic [23:0] s;
    logic        sg;
    logic [7:0]  e;
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Value-level reference: the operand is ({c,sum}) * 2^(e-BIAS-23); find its
  // leading one, normalize as far as the exponent floor allows, round, pack.
  function automatic void model(input logic c, input logic [23:0] s, input logic sg,
                                input logic [7:0] ei, output logic [31:0] res,
                                output logic ovf, output int lat);
    longint m;
    int     e;
    int     k;
    int     p;
    bit     g;
    m = longint'({c, s});
    e = (ei == 8'd0) ? 1 : int'(ei);
    g = 1'b0;
    k = 0;
    if (m >= (64'd1 << 24)) begin
      g = (m % 2) == 1;
      m = m >> 1;
      e = e + 1;
    end else if (m != 0) begin
      p = 0;
      for (int i = 0; i < 24; i++) if (((m >> i) & 1) == 1) p = i;
      k = 23 - p;
      if (k > e - 1) k = e - 1;
      m = m << k;
      e = e - k;
    end
    if (g && (m % 2) == 1) m = m + 1;
    if (m == (64'd1 << 24)) begin
      m = m >> 1;
      e = e + 1;
    end
    lat = k + 2;
    ovf = 1'b0;
    if (m == 0) res = 32'h0;
    else if (e >= 255) begin
      res = {sg, 8'hFF, 23'h0};
      ovf = 1'b1;
    end else if (m < (64'd1 << 23)) res = {sg, 8'h00, 23'(m)};
    else res = {sg, 8'(e), 23'(m)};
  endfunction

  // Called just after a clock edge; en is low on edges stall_at..stall_at+2.
  task automatic run_op(input logic c, input logic [23:0] s, input logic sg,
                        input logic [7:0] ei, input int stall_at,
                        output logic [31:0] res, output logic ovf,
                        output int lat, output bit busy_ok);
    bus.c_out    = c;
    bus.sum      = s;
    bus.sign_in  = sg;
    bus.exp_in   = ei;
    bus.in_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_ready = 1'b0;
    lat     = -1;
    busy_ok = 1'b1;
    for (int n = 1; n <= 60 && lat < 0; n++) begin
      bus.en = !(stall_at > 0 && n >= stall_at && n < stall_at + 3);
      @(posedge clk); #1;
      if (bus.done) begin
        lat = n;
        if (bus.busy) busy_ok = 1'b0;
      end else if (!bus.busy) begin
        busy_ok = 1'b0;
      end
    end
    bus.en = 1'b1;
    res = bus.result;
    ovf = bus.overflow;
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] eres;
    logic        ovf;
    logic        eovf;
    logic [23:0] rs;
    logic [7:0]  re;
    logic        rc;
    logic        rsg;
    int          lat;
    int          elat;
    int          ndone;
    bit          busy_ok;

    tbl[0] = '{1'b1, 24'h800000, 1'b0, 8'd127, 32'h40400000, 1'b0, 2};
    tbl[1] = '{1'b0, 24'h000001, 1'b0, 8'd127, 32'h34000000, 1'b0, 25};
    tbl[2] = '{1'b1, 24'hFFFFFF, 1'b0, 8'd127, 32'h40800000, 1'b0, 2};
    tbl[3] = '{1'b1, 24'h000001, 1'b0, 8'd127, 32'h40000000, 1'b0, 2};
    tbl[4] = '{1'b1, 24'h000000, 1'b1, 8'd254, 32'hFF800000, 1'b1, 2};
    tbl[5] = '{1'b0, 24'h000010, 1'b0, 8'd3,   32'h00000040, 1'b0, 4};
    tbl[6] = '{1'b0, 24'h000000, 1'b1, 8'd127, 32'h00000000, 1'b0, 2};
    tbl[7] = '{1'b1, 24'h000003, 1'b0, 8'd127, 32'h40000002, 1'b0, 2};
    tbl[8] = '{1'b0, 24'h800000, 1'b0, 8'd0,   32'h00800000, 1'b0, 2};

    bus.en = 1'b1;
    bus.in_ready = 1'b0;
    bus.c_out = 1'b0;
    bus.sum = '0;
    bus.sign_in = 1'b0;
    bus.exp_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", bus.result, 32'h0);
    check("reset_done", 32'(bus.done), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_overflow", 32'(bus.overflow), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].c, tbl[i].s, tbl[i].sg, tbl[i].e, 0, res, ovf, lat, busy_ok);
      check($sformatf("vec%0d_result", i), res, tbl[i].res);
      check($sformatf("vec%0d_overflow", i), 32'(ovf), 32'(tbl[i].ovf));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
      check($sformatf("vec%0d_busy", i), 32'(busy_ok), 32'h1);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'h0);
    end

    // Enable dropped for three edges in the middle of normalization.
    run_op(1'b0, 24'h000001, 1'b0, 8'd127, 3, res, ovf, lat, busy_ok);
    check("stall_result", res, 32'h34000000);
    check("stall_latency", 32'(lat), 32'd28);
    @(posedge clk); #1;

    // A second in_ready edge while normalizing is dropped, not queued.
    bus.c_out = 1'b0; bus.sum = 24'h000001; bus.sign_in = 1'b0; bus.exp_in = 8'd127;
    bus.in_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.sum = 24'h000010; bus.exp_in = 8'd3;
    bus.in_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_ready = 1'b0;
    ndone = 0;
    res = '0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        ndone++;
        res = bus.result;
      end
    end
    check("busy_edge_done_count", 32'(ndone), 32'd1);
    check("busy_edge_result", res, 32'h34000000);

    // Back-to-back: new operand arrives during ROUND and is taken at E2.
    bus.c_out = 1'b1; bus.sum = 24'h800000; bus.sign_in = 1'b0; bus.exp_in = 8'd127;
    bus.in_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_ready = 1'b0;
    @(posedge clk); #1;
    bus.c_out = 1'b0; bus.sum = 24'h000010; bus.exp_in = 8'd3;
    bus.in_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_ready = 1'b0;
    check("b2b_first_done", 32'(bus.done), 32'h1);
    check("b2b_first_result", bus.result, 32'h40400000);
    lat = -1;
    for (int n = 3; n <= 30 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (bus.done) lat = n;
    end
    check("b2b_second_latency", 32'(lat), 32'd6);
    check("b2b_second_result", bus.result, 32'h00000040);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of normalization.
    bus.c_out = 1'b0; bus.sum = 24'h000001; bus.exp_in = 8'd127; bus.sign_in = 1'b1;
    bus.in_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_ready = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_result", bus.result, 32'h0);
    check("async_rst_busy", 32'(bus.busy), 32'h0);
    check("async_rst_done", 32'(bus.done), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    ndone = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    check("async_rst_no_done", 32'(ndone), 32'd0);
    run_op(1'b0, 24'h000010, 1'b0, 8'd3, 0, res, ovf, lat, busy_ok);
    check("post_rst_result", res, 32'h00000040);
    check("post_rst_latency", 32'(lat), 32'd4);
    @(posedge clk); #1;

    for (int t = 0; t < 300; t++) begin
      rc  = ($urandom % 4) == 0;
      rs  = 24'($urandom) >> $urandom_range(0, 24);
      rsg = 1'($urandom);
      case ($urandom % 8)
        0: re = 8'd0;
        1: re = 8'd1;
        2: re = 8'($urandom_range(2, 6));
        3: re = 8'($urandom_range(250, 255));
        default: re = 8'($urandom);
      endcase
      model(rc, rs, rsg, re, eres, eovf, elat);
      run_op(rc, rs, rsg, re, 0, res, ovf, lat, busy_ok);
      check($sformatf("rand%0d_result c=%0d s=%h e=%0d", t, rc, rs, re), res, eres);
      check($sformatf("rand%0d_overflow", t), 32'(ovf), 32'(eovf));
      check($sformatf("rand%0d_latency", t), 32'(lat), 32'(elat));
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
